// File: rtl/alu_ctrl_mdu.sv
// rtl/alu_ctrl_mdu.sv - registered ALU control decode with multiply/divide launch and interlock
module alu_ctrl_mdu #(
    parameter int OP_W       = 3,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            flush_i,
    input  logic [5:0]      funct_i,
    input  logic [OP_W-1:0] ALUOp_i,
    output logic            valid_o,
    output logic [3:0]      ALUCtrl_o,
    output logic [1:0]      shamt_ctrl_o,
    output logic            illegal_o,
    output logic            mdu_start_o,
    output logic            mdu_div_o,
    output logic            mdu_signed_o,
    output logic            busy_o,
    output logic            mdu_done_o
);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SHR  = 4'b1000;
    localparam logic [3:0] C_LUI  = 4'b1001;
    localparam logic [3:0] C_BNE  = 4'b1010;
    localparam logic [3:0] C_MUL  = 4'b1011;
    localparam logic [3:0] C_DIV  = 4'b1100;
    localparam logic [3:0] C_MFHI = 4'b1101;
    localparam logic [3:0] C_MFLO = 4'b1110;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dec_ctrl;
    logic [1:0]       dec_shamt;
    logic             dec_illegal;
    logic             is_mdu;
    logic             is_hilo;
    logic             accept;

    always_comb begin
        dec_ctrl    = C_ADD;
        dec_shamt   = 2'b00;
        dec_illegal = 1'b0;
        is_mdu      = 1'b0;
        is_hilo     = 1'b0;
        case (ALUOp_i)
            OP_W'(0): dec_ctrl = C_ADD;
            OP_W'(1): dec_ctrl = C_BNE;
            OP_W'(2): begin
                case (funct_i)
                    6'd32: dec_ctrl = C_ADD;
                    6'd34: dec_ctrl = C_SUB;
                    6'd36: dec_ctrl = C_AND;
                    6'd37: dec_ctrl = C_OR;
                    6'd42: dec_ctrl = C_SLT;
                    6'd3, 6'd7: begin
                        dec_ctrl  = C_SHR;
                        dec_shamt = 2'b01;
                    end
                    6'd16: begin
                        dec_ctrl = C_MFHI;
                        is_hilo  = 1'b1;
                    end
                    6'd18: begin
                        dec_ctrl = C_MFLO;
                        is_hilo  = 1'b1;
                    end
                    6'd24, 6'd25: begin
                        dec_ctrl = C_MUL;
                        is_mdu   = 1'b1;
                    end
                    6'd26, 6'd27: begin
                        dec_ctrl = C_DIV;
                        is_mdu   = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_W'(3): dec_ctrl = C_ADD;
            OP_W'(4): begin
                dec_ctrl  = C_SLT;
                dec_shamt = 2'b10;
            end
            OP_W'(5): dec_ctrl = C_SUB;
            OP_W'(6): dec_ctrl = C_LUI;
            OP_W'(7): begin
                dec_ctrl  = C_OR;
                dec_shamt = 2'b10;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Plain ALU ops bypass the interlock; only HI/LO consumers and new MDU ops wait.
    assign busy_o     = (state_q == BUSY);
    assign mdu_done_o = busy_o && (cnt_q == CNT_W'(1));
    assign ready_o    = !busy_o || !(is_mdu || is_hilo);
    assign accept     = valid_i && ready_o && !flush_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mdu) begin
                    state_d = BUSY;
                    cnt_d   = funct_i[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            valid_o      <= 1'b0;
            ALUCtrl_o    <= 4'b0000;
            shamt_ctrl_o <= 2'b00;
            illegal_o    <= 1'b0;
            mdu_start_o  <= 1'b0;
            mdu_div_o    <= 1'b0;
            mdu_signed_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_o     <= accept;
            mdu_start_o <= accept && is_mdu;
            if (accept) begin
                ALUCtrl_o    <= dec_ctrl;
                shamt_ctrl_o <= dec_shamt;
                illegal_o    <= dec_illegal;
            end
            if (accept && is_mdu) begin
                mdu_div_o    <= funct_i[1];
                mdu_signed_o <= !funct_i[0];
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb/tb_alu_ctrl_mdu.sv - directed and randomized checks of alu_ctrl_mdu against a table/timeline model
module tb_alu_ctrl_mdu;
    localparam int MUL = 4;
    localparam int DIV = 32;

    logic       clk = 1'b0;
    logic       rst, valid, flush;
    logic [5:0] funct;
    logic [2:0] aluop;
    logic       ready_o, valid_o, illegal_o, mdu_start_o, mdu_div_o, mdu_signed_o, busy_o, mdu_done_o;
    logic [3:0] ALUCtrl_o;
    logic [1:0] shamt_ctrl_o;

    always #5 clk = ~clk;

    alu_ctrl_mdu #(.OP_W(3), .MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready_o), .flush_i(flush),
        .funct_i(funct), .ALUOp_i(aluop), .valid_o(valid_o), .ALUCtrl_o(ALUCtrl_o),
        .shamt_ctrl_o(shamt_ctrl_o), .illegal_o(illegal_o), .mdu_start_o(mdu_start_o),
        .mdu_div_o(mdu_div_o), .mdu_signed_o(mdu_signed_o), .busy_o(busy_o), .mdu_done_o(mdu_done_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_end = -1;

    // Model: lookup tables of {shamt, ctrl}, and the MDU as an absolute end-cycle.
    logic [5:0] op_tab [8];
    logic [5:0] f_tab [int];
    logic [5:0] f_pool [15];
    logic       e_valid, e_ill, e_start, e_div, e_sgn;
    logic [3:0] e_ctrl;
    logic [1:0] e_shamt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_cycle(input logic r, input logic v, input logic fl,
                            input logic [2:0] op, input logic [5:0] f);
        logic is_rt, mdu, hilo, rdy, acc;
        rst = r; valid = v; flush = fl; aluop = op; funct = f;
        #1;
        is_rt = (op == 3'd2);
        mdu   = is_rt && (f >= 6'd24) && (f <= 6'd27);
        hilo  = is_rt && (f == 6'd16 || f == 6'd18);
        rdy   = !(cyc <= busy_end) || !(mdu || hilo);
        chk("ready", {7'b0, ready_o}, {7'b0, rdy});
        acc = v && rdy && !fl;
        @(posedge clk);
        if (r) begin
            {e_valid, e_ill, e_start, e_div, e_sgn} = '0;
            e_ctrl = 4'b0000; e_shamt = 2'b00; busy_end = -1;
        end else begin
            e_valid = acc;
            e_start = acc && mdu;
            if (acc) begin
                if (!is_rt) begin
                    {e_shamt, e_ctrl} = op_tab[op]; e_ill = 1'b0;
                end else if (f_tab.exists(int'(f))) begin
                    {e_shamt, e_ctrl} = f_tab[int'(f)]; e_ill = 1'b0;
                end else begin
                    e_ctrl = 4'b0010; e_shamt = 2'b00; e_ill = 1'b1;
                end
            end
            if (acc && mdu) begin
                e_div = f[1]; e_sgn = !f[0];
                busy_end = cyc + (f[1] ? DIV : MUL);
            end
        end
        cyc++;
        @(negedge clk);
        chk("valid_o", {7'b0, valid_o}, {7'b0, e_valid});
        chk("ALUCtrl_o", {4'b0, ALUCtrl_o}, {4'b0, e_ctrl});
        chk("shamt_ctrl_o", {6'b0, shamt_ctrl_o}, {6'b0, e_shamt});
        chk("illegal_o", {7'b0, illegal_o}, {7'b0, e_ill});
        chk("mdu_start_o", {7'b0, mdu_start_o}, {7'b0, e_start});
        chk("mdu_div_o", {7'b0, mdu_div_o}, {7'b0, e_div});
        chk("mdu_signed_o", {7'b0, mdu_signed_o}, {7'b0, e_sgn});
        chk("busy_o", {7'b0, busy_o}, {7'b0, logic'(cyc <= busy_end)});
        chk("mdu_done_o", {7'b0, mdu_done_o}, {7'b0, logic'(cyc == busy_end)});
    endtask

    initial begin
        op_tab = '{6'b00_0010, 6'b00_1010, 6'b00_0010, 6'b00_0010,
                   6'b10_0111, 6'b00_0110, 6'b00_1001, 6'b10_0001};
        f_tab[32] = 6'b00_0010; f_tab[34] = 6'b00_0110; f_tab[36] = 6'b00_0000;
        f_tab[37] = 6'b00_0001; f_tab[42] = 6'b00_0111; f_tab[3]  = 6'b01_1000;
        f_tab[7]  = 6'b01_1000; f_tab[16] = 6'b00_1101; f_tab[18] = 6'b00_1110;
        f_tab[24] = 6'b00_1011; f_tab[25] = 6'b00_1011; f_tab[26] = 6'b00_1100;
        f_tab[27] = 6'b00_1100;
        f_pool = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd3, 6'd7, 6'd16,
                   6'd18, 6'd24, 6'd25, 6'd26, 6'd27, 6'd9, 6'd0};

        rst = 1'b1; valid = 1'b0; flush = 1'b0; aluop = '0; funct = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        do_cycle(1, 0, 0, 3'd0, 6'd0);
        do_cycle(0, 1, 0, 3'd2, 6'd34);
        do_cycle(0, 0, 0, 3'd2, 6'd34);
        do_cycle(0, 1, 0, 3'd2, 6'd3);
        do_cycle(0, 1, 0, 3'd4, 6'd0);
        do_cycle(0, 1, 0, 3'd6, 6'd0);
        do_cycle(0, 1, 0, 3'd2, 6'd9);
        // mult, then mflo held until the interlock releases
        do_cycle(0, 1, 0, 3'd2, 6'd24);
        repeat (6) do_cycle(0, 1, 0, 3'd2, 6'd18);
        // divu followed by an add that slips past the busy MDU
        do_cycle(0, 1, 0, 3'd2, 6'd27);
        do_cycle(0, 1, 0, 3'd2, 6'd32);
        do_cycle(0, 1, 1, 3'd2, 6'd32);
        do_cycle(0, 0, 1, 3'd2, 6'd32);
        repeat (31) do_cycle(0, 0, 0, 3'd0, 6'd0);
        // div interrupted by reset, then mfhi goes straight through
        do_cycle(0, 1, 0, 3'd2, 6'd26);
        do_cycle(0, 0, 0, 3'd0, 6'd0);
        do_cycle(1, 0, 0, 3'd0, 6'd0);
        do_cycle(0, 1, 0, 3'd2, 6'd16);
        do_cycle(0, 0, 0, 3'd0, 6'd0);

        for (int i = 0; i < 600; i++) begin
            do_cycle(logic'($urandom_range(0, 149) == 0), logic'($urandom_range(0, 3) != 0),
                     logic'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                     f_pool[$urandom_range(0, 14)]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
